// File: rtl/bus_turn_arbiter.sv
// Bus ownership sequencer for the shared PHY/memory data bus: turnaround, burst limit, grant handshake.
// Optional build macro BUS_ARB_ROUND_ROBIN_EN: alternate owners under contention instead of fixed RX priority.
module bus_turn_arbiter #(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_BURST   = 64,
  parameter int CNT_W       = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_req_i,
  input  logic tx_req_i,
  input  logic rx_done_i,
  input  logic tx_done_i,
  output logic rx_gnt_o,
  output logic tx_gnt_o,
  output logic tx_oe,
  output logic bus_hiz_o,
  output logic burst_abort_o
);

  typedef enum logic [1:0] {IDLE, TURN, ACTIVE, RELEASE} state_t;

  localparam logic [3:0]       TURN_LAST  = 4'(TURN_CYCLES);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  state_t           state_q, state_d;
  logic [3:0]       turn_cnt_q, turn_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             sel_tx_q, sel_tx_d;
  logic             tx_oe_q, tx_oe_d;
  logic             rx_gnt_q, rx_gnt_d;
  logic             tx_gnt_q, tx_gnt_d;
  logic             hiz_q, hiz_d;
  logic             abort_q, abort_d;
  logic             pick_tx;
  logic             sel_done;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // last_tx_q resets to TX so that RX wins the first contended arbitration
  logic last_tx_q, last_tx_d;

  always_comb begin
    pick_tx   = tx_req_i && (!rx_req_i || !last_tx_q);
    last_tx_d = (state_q == RELEASE) ? sel_tx_q : last_tx_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_tx_q <= 1'b1;
    end else begin
      last_tx_q <= last_tx_d;
    end
  end
`else
  always_comb begin
    pick_tx = tx_req_i && !rx_req_i;
  end
`endif

  always_comb begin
    state_d     = state_q;
    turn_cnt_d  = turn_cnt_q;
    burst_cnt_d = burst_cnt_q;
    sel_tx_d    = sel_tx_q;
    tx_oe_d     = tx_oe_q;
    abort_d     = 1'b0;
    sel_done    = sel_tx_q ? tx_done_i : rx_done_i;

    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        // Direction is committed here and held through turnaround, burst and release
        if (rx_req_i || tx_req_i) begin
          sel_tx_d   = pick_tx;
          tx_oe_d    = pick_tx;
          turn_cnt_d = 4'd1;
          state_d    = TURN;
        end
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d     = ACTIVE;
          burst_cnt_d = CNT_W'(1);
        end else begin
          turn_cnt_d = turn_cnt_q + 4'd1;
        end
      end
      ACTIVE: begin
        if (sel_done) begin
          state_d = RELEASE;
        end else if (burst_cnt_q == BURST_LAST) begin
          state_d = RELEASE;
          abort_d = 1'b1;
        end else begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
        turn_cnt_d  = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered
    rx_gnt_d = (state_d == ACTIVE) && !sel_tx_d;
    tx_gnt_d = (state_d == ACTIVE) && sel_tx_d;
    hiz_d    = (state_d != ACTIVE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      turn_cnt_q  <= '0;
      burst_cnt_q <= '0;
      sel_tx_q    <= 1'b0;
      tx_oe_q     <= 1'b0;
      rx_gnt_q    <= 1'b0;
      tx_gnt_q    <= 1'b0;
      hiz_q       <= 1'b1;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_cnt_q  <= turn_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      sel_tx_q    <= sel_tx_d;
      tx_oe_q     <= tx_oe_d;
      rx_gnt_q    <= rx_gnt_d;
      tx_gnt_q    <= tx_gnt_d;
      hiz_q       <= hiz_d;
      abort_q     <= abort_d;
    end
  end

  assign rx_gnt_o      = rx_gnt_q;
  assign tx_gnt_o      = tx_gnt_q;
  assign tx_oe         = tx_oe_q;
  assign bus_hiz_o     = hiz_q;
  assign burst_abort_o = abort_q;

endmodule

// File: tb/tb_bus_turn_arbiter.sv
// Self-checking bench for bus_turn_arbiter: elapsed-cycle model compared every cycle plus directed literal checks.
module tb_bus_turn_arbiter;

  localparam int TC = 1;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rx_req, tx_req, rx_done, tx_done;
  logic rx_gnt, tx_gnt, tx_oe, bus_hiz, burst_abort;

  bus_turn_arbiter #(.TURN_CYCLES(TC), .MAX_BURST(MB), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_req_i(rx_req), .tx_req_i(tx_req),
    .rx_done_i(rx_done), .tx_done_i(tx_done),
    .rx_gnt_o(rx_gnt), .tx_gnt_o(tx_gnt), .tx_oe(tx_oe),
    .bus_hiz_o(bus_hiz), .burst_abort_o(burst_abort)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the request was accepted; cycles 1..TC are
  // turnaround, cycle TC+b is beat b. A release cycle follows the last beat.
  bit m_valid = 1'b0;
  bit m_busy, m_rel, m_abort, m_side, m_oe, m_done, m_act;
  int m_t;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  bit m_last;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_rel = 0; m_abort = 0; m_oe = 0; m_t = 0; m_side = 0;
      m_valid = 1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      m_last = 1;
`endif
    end else if (m_rel) begin
      m_rel = 0; m_abort = 0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      m_last = m_side;
`endif
    end else if (m_busy) begin
      if (m_t > TC) begin
        m_done = m_side ? tx_done : rx_done;
        if (m_done || (m_t - TC) == MB) begin
          m_busy = 0; m_rel = 1; m_abort = !m_done;
        end else begin
          m_t++;
        end
      end else begin
        m_t++;
      end
    end else if (rx_req || tx_req) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      m_side = tx_req && (!rx_req || !m_last);
`else
      m_side = !rx_req;
`endif
      m_oe = m_side; m_busy = 1; m_t = 1;
    end
    #1;
    if (m_valid) begin
      m_act = m_busy && (m_t > TC);
      chk("model_rx_gnt", 32'(rx_gnt), 32'(m_act && !m_side));
      chk("model_tx_gnt", 32'(tx_gnt), 32'(m_act && m_side));
      chk("model_tx_oe", 32'(tx_oe), 32'(m_oe));
      chk("model_hiz", 32'(bus_hiz), 32'(!m_act));
      chk("model_abort", 32'(burst_abort), 32'(m_rel && m_abort));
      chk("gnt_exclusive", 32'(rx_gnt & tx_gnt), 32'd0);
      chk("hiz_one_gnt", 32'(bus_hiz | (rx_gnt ^ tx_gnt)), 32'd1);
    end
  end

  task automatic do_reset(input bit rxr, input bit txr);
    rst = 1; rx_req = rxr; tx_req = txr; rx_done = 0; tx_done = 0;
    repeat (2) @(negedge clk);
  endtask

  logic [15:0] h_a, h_b, h_c, h_d;
  int beat, rx_bursts, tx_bursts;

  initial begin
    // Reset with both requests high, then continuous contention
    do_reset(1, 1);
    chk("rst_rx_gnt", 32'(rx_gnt), 32'd0);
    chk("rst_tx_gnt", 32'(tx_gnt), 32'd0);
    chk("rst_tx_oe", 32'(tx_oe), 32'd0);
    chk("rst_hiz", 32'(bus_hiz), 32'd1);
    chk("rst_abort", 32'(burst_abort), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("first_turn_hiz", 32'(bus_hiz), 32'd1);
    chk("first_turn_oe", 32'(tx_oe), 32'd0);
    chk("first_turn_gnt", 32'(rx_gnt | tx_gnt), 32'd0);
    beat = 0; rx_bursts = 0; tx_bursts = 0;
    for (int i = 1; i < 31; i++) begin
      @(negedge clk);
      if (rx_gnt || tx_gnt) beat++; else beat = 0;
      if (beat == 1) begin
        if (rx_gnt) rx_bursts++; else tx_bursts++;
      end
      rx_done = (beat == 2);
      tx_done = (beat == 2);
    end
`ifdef BUS_ARB_ROUND_ROBIN_EN
    chk("contend_rx_bursts", 32'(rx_bursts), 32'd3);
    chk("contend_tx_bursts", 32'(tx_bursts), 32'd3);
`else
    chk("contend_rx_bursts", 32'(rx_bursts), 32'd6);
    chk("contend_tx_bursts", 32'(tx_bursts), 32'd0);
`endif
    $display("[TB] contention: rx_bursts=%0d tx_bursts=%0d", rx_bursts, tx_bursts);

    // Single TX burst, done on 4th beat (coincides with limit: no abort)
    do_reset(0, 0);
    rst = 0; tx_req = 1;
    h_a = '0; h_b = '0; h_c = '0; h_d = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      h_a[i] = tx_gnt; h_b[i] = tx_oe; h_c[i] = bus_hiz; h_d[i] = burst_abort | rx_gnt;
      if (i == 1) tx_req = 0;
      tx_done = (i == 4);
    end
    chk("tx_burst_gnt", 32'(h_a), 32'h1E);
    chk("tx_burst_oe", 32'(h_b), 32'hFF);
    chk("tx_burst_hiz", 32'(h_c), 32'hE1);
    chk("tx_burst_abort_rxgnt", 32'(h_d), 32'h0);
    $display("[TB] tx burst: gnt=%h oe=%h hiz=%h", h_a, h_b, h_c);

    // Burst limit: RX held, never done
    do_reset(0, 0);
    rst = 0; rx_req = 1;
    h_a = '0; h_b = '0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      h_a[i] = rx_gnt; h_b[i] = burst_abort;
    end
    rx_req = 0;
    chk("limit_gnt", 32'(h_a), 32'h0F1E);
    chk("limit_abort", 32'(h_b), 32'h1020);
    $display("[TB] burst limit: gnt=%h abort=%h", h_a, h_b);

    // Done on the limit beat: done wins, no abort
    do_reset(0, 0);
    rst = 0; rx_req = 1;
    h_a = '0; h_b = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      h_a[i] = rx_gnt; h_b[i] = burst_abort;
      if (i == 1) rx_req = 0;
      rx_done = (i == 4);
    end
    chk("done_limit_gnt", 32'(h_a), 32'h1E);
    chk("done_limit_abort", 32'(h_b), 32'h0);
    $display("[TB] done on limit: gnt=%h abort=%h", h_a, h_b);

    // Reset on the 2nd TX grant cycle
    do_reset(0, 0);
    rst = 0; tx_req = 1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("midrst_pre_gnt", 32'(tx_gnt), 32'd1);
    rst = 1;
    @(negedge clk);
    chk("midrst_tx_gnt", 32'(tx_gnt), 32'd0);
    chk("midrst_tx_oe", 32'(tx_oe), 32'd0);
    chk("midrst_hiz", 32'(bus_hiz), 32'd1);
    rst = 0; tx_req = 0;
    repeat (3) @(negedge clk);
    chk("midrst_idle_hiz", 32'(bus_hiz), 32'd1);
    $display("[TB] mid-active reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_turn_arbiter.md
Name: bus_turn_arbiter

Overview:
- Sequences ownership of the shared 8-bit bidirectional data bus between the physical interface (receive path: PHY drives, memory captures) and the memory (transmit path: memory drives, PHY captures).
- Generates the tx_oe direction select consumed by both blocks and a bus high-Z qualifier.
- Inserts turnaround cycles on every ownership change, enforces a maximum burst length, and grants bus access with a request/grant/done handshake.
- Sits inside the device top level, alongside the PHY and memory instances.

Parameters:
- TURN_CYCLES, 1, high-Z cycles inserted before each grant; legal range 1..15.
- MAX_BURST, 64, maximum ACTIVE cycles per grant before forced release; legal range 1..255.
- CNT_W, 8, width of the burst counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- rx_req_i  in  1  PHY requests the bus to push received data to memory; level, held until granted
- tx_req_i  in  1  memory requests the bus to send data to PHY; level, held until granted
- rx_done_i  in  1  PHY last beat; sampled only while rx_gnt_o=1
- tx_done_i  in  1  memory last beat; sampled only while tx_gnt_o=1
- rx_gnt_o  out  1  PHY owns the bus this cycle
- tx_gnt_o  out  1  memory owns the bus this cycle
- tx_oe  out  1  bus direction: 1 = memory drives toward PHY, 0 = PHY drives toward memory
- bus_hiz_o  out  1  1 = no agent may drive data_io this cycle
- burst_abort_o  out  1  one-cycle pulse when a grant is revoked by the MAX_BURST limit

Behaviour:
- One clock (clk_i); reset is synchronous and active-high (rst_i). All outputs are registered.
- Reset values: rx_gnt_o=0, tx_gnt_o=0, tx_oe=0, bus_hiz_o=1, burst_abort_o=0, state=IDLE, counters=0.
- Reset mid-operation: on the next edge, return to IDLE with reset output values. No release cycle is inserted; the grant drops immediately.
- FSM states: IDLE, TURN, ACTIVE, RELEASE.
- IDLE: bus_hiz_o=1, no grant.
  - If rx_req_i=1: select RX, tx_oe<=0, go to TURN.
  - Else if tx_req_i=1: select TX, tx_oe<=1, go to TURN.
  - Both requesting: RX wins (fixed priority, unless the optional feature is compiled in).
- TURN: bus_hiz_o=1, no grant. Stays exactly TURN_CYCLES cycles, then goes to ACTIVE.
  - tx_oe changes only on the IDLE->TURN edge, so the direction is stable for the whole turnaround.
- ACTIVE: bus_hiz_o=0; gnt of the selected side =1; burst counter increments each cycle starting from 1.
  - If the selected done_i=1 in a cycle, that cycle is the last beat; go to RELEASE.
  - Else if counter==MAX_BURST, go to RELEASE and pulse burst_abort_o in the first RELEASE cycle.
  - If done and limit coincide, done wins and no abort pulse is issued.
- RELEASE: one cycle, bus_hiz_o=1, no grant, tx_oe held. Then IDLE, counter cleared.
- Latency: a request seen high in IDLE at edge n produces TURN from n+1 and the grant from n+1+TURN_CYCLES.
  - Minimum idle gap between consecutive grants = 1 (RELEASE) + 1 (IDLE) + TURN_CYCLES.
- Request deassertion during TURN: proceed to ACTIVE anyway. The requester must then assert done on the first ACTIVE cycle; no cancel path exists.
- The non-selected request is ignored until IDLE. The non-selected done input is always ignored.
- At no cycle may rx_gnt_o and tx_gnt_o both be 1. In every cycle where bus_hiz_o=0, exactly one grant is 1.

Optional Feature:
- Macro: BUS_ARB_ROUND_ROBIN_EN.
- Defined: a last_owner flop (reset to TX, so RX wins first) is updated in RELEASE. When both requests are high in IDLE, the side that did not own the bus last is granted.
- Undefined: fixed RX priority and no last_owner flop.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles with both requests high -> all grants 0, tx_oe=0, bus_hiz_o=1; first TURN begins one cycle after rst_i falls.
- Single TX burst, TURN_CYCLES=1: tx_req_i high at edge 0, tx_done_i on 4th grant cycle -> tx_oe=1 from cycle 1, tx_gnt_o high cycles 2-5, RELEASE at cycle 6, IDLE at 7.
- Contention, fixed priority: both requests high continuously, done after 2 beats each -> grants go RX, RX, RX...; tx_gnt_o never asserts. With BUS_ARB_ROUND_ROBIN_EN defined -> RX, TX, RX, TX; tx_oe toggles only in TURN-entry cycles.
- Burst limit, MAX_BURST=4: rx_req_i held, rx_done_i never asserted -> rx_gnt_o high exactly 4 cycles, burst_abort_o single pulse in the RELEASE cycle; re-grant after TURN.
- Done on limit cycle, MAX_BURST=4: rx_done_i on beat 4 -> no burst_abort_o pulse.
- Reset mid-ACTIVE: rst_i asserted on the 2nd TX grant cycle -> next cycle tx_gnt_o=0, tx_oe=0, bus_hiz_o=1, state IDLE; no overlapping grants at any point (assertion checked throughout).
